// File: rtl/mp3_ctrl_panel.sv
// MP3 player control panel: button/switch conditioning and song, pause, volume and tone-preset registers.
// Latency: raw input edge to output change is 2 (sync) + DEBOUNCE_CYCLES + 1 clk cycles.
// Backpressure: none; presses are one-cycle events applied in the cycle they occur.
//
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   btn_next/prev/vol_up/
//   btn_vol_down/btn_pause     raw asynchronous active-high buttons
//   sw_effect[1:0]             raw asynchronous tone-preset switches
//   i_finish_song              playback core level, high once the current song has ended
//   o_song_select[2:0]         song index to the playback core
//   o_pause                    pause request to the playback core
//   o_vol[15:0]                volume register value {level, level}, 8'h00 loudest, 8'hFE silent
//   o_effect[15:0]             bass/treble register value
module mp3_ctrl_panel #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SONG_NUM        = 4,
  parameter logic [7:0]  VOL_STEP        = 8'h10,
  parameter logic [7:0]  VOL_INIT        = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic        btn_vol_up,
  input  logic        btn_vol_down,
  input  logic        btn_pause,
  input  logic [1:0]  sw_effect,
  input  logic        i_finish_song,
  output logic [2:0]  o_song_select,
  output logic        o_pause,
  output logic [15:0] o_vol,
  output logic [15:0] o_effect
);

  // Conditioned input bit positions: five buttons, then the two switch bits.
  localparam int NIN    = 7;
  localparam int NBTN   = 5;
  localparam int B_NEXT = 0;
  localparam int B_PREV = 1;
  localparam int B_VUP  = 2;
  localparam int B_VDN  = 3;
  localparam int B_PAUS = 4;

  // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    SONG_LAST = 3'(SONG_NUM - 1);

  logic [NIN-1:0]  raw;
  logic [NIN-1:0]  sync1_q, sync2_q;
  logic [NIN-1:0]  stable_q, stable_d;
  logic [NBTN-1:0] stable_prev_q;
  logic [CW-1:0]   cnt_q [NIN];
  logic [CW-1:0]   cnt_d [NIN];

  logic            fin_q, fin_arm_q;
  logic [2:0]      song_q, song_d;
  logic            pause_q, pause_d;
  logic [7:0]      level_q, level_d;
  logic [15:0]     effect_q, effect_d;

  logic [NBTN-1:0] press;
  logic            fin_edge;
  logic            song_inc, song_dec, song_chg;
  logic [8:0]      level_sum;

  assign raw = {sw_effect, btn_pause, btn_vol_down, btn_vol_up, btn_prev, btn_next};

  // Two-flop synchronizers for every raw input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debouncers: count consecutive cycles of disagreement; any agreement
  // restarts the count, so bounces shorter than the window are discarded.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NIN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NIN; i++) begin
        cnt_q[i] <= '0;
      end
      stable_q      <= '0;
      stable_prev_q <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      stable_q      <= stable_d;
      stable_prev_q <= stable_q[NBTN-1:0];
    end
  end

  // Press is the registered rising edge of the stable level: exactly one cycle.
  assign press = stable_q[NBTN-1:0] & ~stable_prev_q;

  // Finish edge detect. The arm flag keeps a level that is already high when
  // reset is released from being mistaken for a new song end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_q     <= 1'b0;
      fin_arm_q <= 1'b0;
    end else begin
      fin_q     <= i_finish_song;
      fin_arm_q <= 1'b1;
    end
  end

  assign fin_edge = i_finish_song & ~fin_q & fin_arm_q;

  // Song select and pause. Simultaneous next+prev cancel; any button
  // activity on next/prev masks a coincident finish edge.
  always_comb begin
    song_inc = 1'b0;
    song_dec = 1'b0;
    if (press[B_NEXT] && !press[B_PREV]) begin
      song_inc = 1'b1;
    end else if (press[B_PREV] && !press[B_NEXT]) begin
      song_dec = 1'b1;
    end else if (!press[B_NEXT] && !press[B_PREV] && fin_edge) begin
      song_inc = 1'b1;
    end
    song_chg = song_inc | song_dec;

    song_d = song_q;
    if (song_inc) begin
      song_d = (song_q >= SONG_LAST) ? 3'd0 : song_q + 3'd1;
    end else if (song_dec) begin
      song_d = (song_q == 3'd0) ? SONG_LAST : song_q - 3'd1;
    end

    // A song change always resumes playback, overriding a pause press.
    pause_d = pause_q;
    if (song_chg) begin
      pause_d = 1'b0;
    end else if (press[B_PAUS]) begin
      pause_d = ~pause_q;
    end
  end

  // Volume attenuation: up lowers attenuation toward 8'h00, down raises it
  // toward 8'hFE. The 9-bit sum catches overflow before clamping.
  always_comb begin
    level_sum = {1'b0, level_q} + {1'b0, VOL_STEP};
    level_d   = level_q;
    if (press[B_VUP] && !press[B_VDN]) begin
      level_d = (level_q < VOL_STEP) ? 8'h00 : level_q - VOL_STEP;
    end else if (press[B_VDN] && !press[B_VUP]) begin
      level_d = (level_sum > 9'h0FE) ? 8'hFE : level_sum[7:0];
    end
  end

  // Tone preset driven only from the debounced switch levels.
  always_comb begin
    effect_d = 16'h0000;
    case (stable_q[NIN-1:NBTN])
      2'b00:   effect_d = 16'h0000;
      2'b01:   effect_d = 16'h00F6;
      2'b10:   effect_d = 16'h7A00;
      default: effect_d = 16'h7AF6;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      song_q   <= 3'd0;
      pause_q  <= 1'b0;
      level_q  <= VOL_INIT;
      effect_q <= 16'h0000;
    end else begin
      song_q   <= song_d;
      pause_q  <= pause_d;
      level_q  <= level_d;
      effect_q <= effect_d;
    end
  end

  assign o_song_select = song_q;
  assign o_pause       = pause_q;
  assign o_vol         = {level_q, level_q};
  assign o_effect      = effect_q;

endmodule

// File: tb/tb_mp3_ctrl_panel.sv
// Directed bench for mp3_ctrl_panel with a 4-cycle debounce window.
// Latency: checks sample 1 time unit after each rising clock edge.
// Backpressure: not applicable; stimulus is a fixed linear sequence.
module tb_mp3_ctrl_panel;

  logic        clk;
  logic        rst_n;
  logic [4:0]  btn;          // 0 next, 1 prev, 2 vol_up, 3 vol_down, 4 pause
  logic [1:0]  sw_effect;
  logic        i_finish_song;
  logic [2:0]  o_song_select;
  logic        o_pause;
  logic [15:0] o_vol;
  logic [15:0] o_effect;

  int errors = 0;
  int checks = 0;

  mp3_ctrl_panel #(
    .DEBOUNCE_CYCLES (4),
    .SONG_NUM        (4),
    .VOL_STEP        (8'h10),
    .VOL_INIT        (8'h20)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_next      (btn[0]),
    .btn_prev      (btn[1]),
    .btn_vol_up    (btn[2]),
    .btn_vol_down  (btn[3]),
    .btn_pause     (btn[4]),
    .sw_effect     (sw_effect),
    .i_finish_song (i_finish_song),
    .o_song_select (o_song_select),
    .o_pause       (o_pause),
    .o_vol         (o_vol),
    .o_effect      (o_effect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Clean press: hold well past the debounce window, then release and settle.
  task automatic press(input int idx);
    btn[idx] = 1'b1;
    ticks(10);
    btn[idx] = 1'b0;
    ticks(10);
  endtask

  initial begin
    rst_n         = 1'b0;
    btn           = '0;
    sw_effect     = 2'b00;
    i_finish_song = 1'b0;
    ticks(3);
    chk("rst_song",   16'(o_song_select), 16'h0000);
    chk("rst_pause",  16'(o_pause),       16'h0000);
    chk("rst_vol",    o_vol,              16'h2020);
    chk("rst_effect", o_effect,           16'h0000);
    rst_n = 1'b1;
    ticks(3);
    chk("idle_song", 16'(o_song_select), 16'h0000);

    // Three clean next presses, first one checked for exact latency.
    btn[0] = 1'b1;
    ticks(6);
    chk("next_lat_before", 16'(o_song_select), 16'h0000);
    tick();
    chk("next_lat_at", 16'(o_song_select), 16'h0001);
    ticks(3);
    btn[0] = 1'b0;
    ticks(10);
    chk("next1", 16'(o_song_select), 16'h0001);
    press(0);
    chk("next2", 16'(o_song_select), 16'h0002);
    press(0);
    chk("next3", 16'(o_song_select), 16'h0003);
    press(0);
    chk("next_wrap", 16'(o_song_select), 16'h0000);

    // Bouncy prev: 2 high, 1 low, 3 high -> rejected; then held 10 -> one press.
    btn[1] = 1'b1; ticks(2);
    btn[1] = 1'b0; tick();
    btn[1] = 1'b1; ticks(3);
    btn[1] = 1'b0; ticks(10);
    chk("prev_bounce", 16'(o_song_select), 16'h0000);
    btn[1] = 1'b1; ticks(10);
    chk("prev_wrap", 16'(o_song_select), 16'h0003);
    btn[1] = 1'b0; ticks(10);
    chk("prev_once", 16'(o_song_select), 16'h0003);

    // Volume: up saturates at 00, down saturates at FE.
    press(2);
    chk("vol_up1", o_vol, 16'h1010);
    press(2);
    chk("vol_up2", o_vol, 16'h0000);
    press(2);
    chk("vol_up_sat", o_vol, 16'h0000);
    for (int i = 0; i < 15; i++) press(3);
    chk("vol_dn15", o_vol, 16'hF0F0);
    press(3);
    chk("vol_dn_sat", o_vol, 16'hFEFE);
    press(3);
    chk("vol_dn_hold", o_vol, 16'hFEFE);

    // Pause, volume while paused, then finish edge advances and unpauses.
    press(4);
    chk("pause_on", 16'(o_pause), 16'h0001);
    press(2);
    chk("vol_paused", o_vol, 16'hEEEE);
    chk("still_paused", 16'(o_pause), 16'h0001);
    i_finish_song = 1'b1;
    tick();
    chk("finish_song", 16'(o_song_select), 16'h0000);
    chk("finish_pause", 16'(o_pause), 16'h0000);
    ticks(5);
    chk("finish_held", 16'(o_song_select), 16'h0000);
    i_finish_song = 1'b0;
    tick();

    // Next and prev together cancel.
    btn[1:0] = 2'b11; ticks(10);
    chk("np_cancel", 16'(o_song_select), 16'h0000);
    btn[1:0] = 2'b00; ticks(10);
    chk("np_cancel_rel", 16'(o_song_select), 16'h0000);

    // Next press coinciding with a finish edge advances only once.
    btn[0] = 1'b1;
    ticks(6);
    i_finish_song = 1'b1;
    tick();
    chk("next_fin", 16'(o_song_select), 16'h0001);
    ticks(5);
    chk("next_fin_once", 16'(o_song_select), 16'h0001);
    btn[0] = 1'b0;
    i_finish_song = 1'b0;
    ticks(10);

    // Prev and pause together: song changes and pause ends at 0.
    press(4);
    chk("pause_on2", 16'(o_pause), 16'h0001);
    btn[1] = 1'b1;
    btn[4] = 1'b1;
    ticks(10);
    chk("prev_pause_song", 16'(o_song_select), 16'h0000);
    chk("prev_pause_p", 16'(o_pause), 16'h0000);
    btn[1] = 1'b0;
    btn[4] = 1'b0;
    ticks(10);

    // Tone presets: switch bounce ignored, each stable value mapped.
    sw_effect = 2'b01; ticks(2);
    sw_effect = 2'b00; ticks(10);
    chk("eff_bounce", o_effect, 16'h0000);
    sw_effect = 2'b01; ticks(10);
    chk("eff_01", o_effect, 16'h00F6);
    sw_effect = 2'b10; ticks(10);
    chk("eff_10", o_effect, 16'h7A00);
    sw_effect = 2'b11; ticks(10);
    chk("eff_11", o_effect, 16'h7AF6);

    // Reset mid-debounce with a button held through release.
    press(0);
    press(4);
    chk("pre_rst_song", 16'(o_song_select), 16'h0001);
    chk("pre_rst_pause", 16'(o_pause), 16'h0001);
    btn[0] = 1'b1;
    ticks(4);
    rst_n = 1'b0;
    #1;
    chk("arst_song",   16'(o_song_select), 16'h0000);
    chk("arst_pause",  16'(o_pause),       16'h0000);
    chk("arst_vol",    o_vol,              16'h2020);
    chk("arst_effect", o_effect,           16'h0000);
    ticks(3);
    rst_n = 1'b1;
    ticks(6);
    chk("rel_song_before", 16'(o_song_select), 16'h0000);
    chk("rel_eff_before",  o_effect,           16'h0000);
    tick();
    chk("rel_song_at", 16'(o_song_select), 16'h0001);
    chk("rel_eff_at",  o_effect,           16'h7AF6);
    chk("rel_vol",     o_vol,              16'h2020);
    ticks(5);
    btn[0] = 1'b0;
    ticks(10);
    chk("rel_once", 16'(o_song_select), 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
